clock_switch_ctrl: RTL and testbench

- Sequences run-time CPU clock-source changes for the board's clock selection path; sits between the four raw clock sources, DIP switches 7/6 and the CPU clock input (divided by six downstream).
- Debounces the speed switches, then switches sources glitch-free: old source parked low, idle gap, new source released only on its low phase.
- Runs entirely in the pll0_250MHz domain; source clocks are sampled as data.

---
 rtl/clk_sel_pkg.sv | 16 +
 rtl/sw_debounce.sv | 40 ++++
 rtl/clock_switch_ctrl.sv | 143 ++++++++++++++
 tb/tb_clock_switch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// rtl/clk_sel_pkg.sv - source-select encodings and clock-switch FSM states
package clk_sel_pkg;

    localparam logic [1:0] SEL_50M = 2'b11;
    localparam logic [1:0] SEL_31K = 2'b10;
    localparam logic [1:0] SEL_2M  = 2'b01;
    localparam logic [1:0] SEL_250 = 2'b00;

    typedef enum logic [1:0] {
        RUN,
        WAIT_OLD_LOW,
        GAP,
        WAIT_NEW_LOW
    } sw_state_t;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - stability-count debouncer for already-synchronized panel switches
module sw_debounce #(
    parameter int WIDTH  = 2,
    parameter int CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic             change
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] cand_q;
    logic [CW-1:0]    cnt;

    // Any movement of the candidate, or agreement with the stable value, restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            stable <= '0;
            cnt    <= '0;
            change <= 1'b0;
        end else begin
            cand_q <= din;
            change <= 1'b0;
            if (din != cand_q || din == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                stable <= din;
                change <= 1'b1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - glitch-free run-time CPU clock source switcher
module clock_switch_ctrl
    import clk_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int GAP_CYCLES      = 16,
    parameter int WAIT_MAX        = 1_048_575,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       pll0_250MHz,
    input  logic       n_reset,
    input  logic       MHz50,
    input  logic       KHz31,
    input  logic       MHz2,
    input  logic       Hz250,
    input  logic [1:0] sw,
    output logic       cpuclk,
    output logic [1:0] sel,
    output logic       busy,
    output logic       sw_ack
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);

    logic [5:0] sync_pipe [SYNC_STAGES];
    logic [3:0] s_src;
    logic [1:0] s_sw;
    logic [1:0] deb_val;
    logic       deb_chg;

    sw_state_t  state, state_d;
    logic [1:0] sel_d, target, target_d;
    logic       busy_d, cpuclk_d, ack_d, pend, pend_d, wait_hit;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [WW-1:0] wait_cnt, wait_d;

    // Source clocks are plain data here; bit index matches the select encoding.
    always_ff @(posedge pll0_250MHz or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
        end else begin
            sync_pipe[0] <= {sw, MHz50, KHz31, MHz2, Hz250};
            for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    assign s_src    = sync_pipe[SYNC_STAGES-1][3:0];
    assign s_sw     = sync_pipe[SYNC_STAGES-1][5:4];
    assign wait_hit = (wait_cnt == WW'(WAIT_MAX));

    sw_debounce #(
        .WIDTH  (2),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk    (pll0_250MHz),
        .rst_n  (n_reset),
        .din    (s_sw),
        .stable (deb_val),
        .change (deb_chg)
    );

    always_ff @(posedge pll0_250MHz or negedge n_reset) begin
        if (!n_reset) begin
            state    <= RUN;
            sel      <= SEL_250;
            target   <= SEL_250;
            busy     <= 1'b0;
            cpuclk   <= 1'b0;
            sw_ack   <= 1'b0;
            pend     <= 1'b0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            target   <= target_d;
            busy     <= busy_d;
            cpuclk   <= cpuclk_d;
            sw_ack   <= ack_d;
            pend     <= pend_d;
            gap_cnt  <= gap_d;
            wait_cnt <= wait_d;
        end
    end

    // A change seen while a switch is in flight is remembered and re-evaluated back in RUN.
    always_comb begin
        state_d  = state;
        sel_d    = sel;
        target_d = target;
        busy_d   = busy;
        cpuclk_d = s_src[sel];
        ack_d    = 1'b0;
        pend_d   = pend | deb_chg;
        gap_d    = gap_cnt;
        wait_d   = wait_cnt;
        case (state)
            RUN: begin
                pend_d = 1'b0;
                if ((deb_chg || pend) && deb_val != sel) begin
                    ack_d    = 1'b1;
                    target_d = deb_val;
                    busy_d   = 1'b1;
                    wait_d   = '0;
                    state_d  = WAIT_OLD_LOW;
                end
            end
            WAIT_OLD_LOW: begin
                if (!s_src[sel] || wait_hit) begin
                    cpuclk_d = 1'b0;
                    gap_d    = '0;
                    wait_d   = '0;
                    state_d  = GAP;
                end else begin
                    wait_d = wait_cnt + WW'(1);
                end
            end
            GAP: begin
                cpuclk_d = 1'b0;
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    sel_d   = target;
                    gap_d   = '0;
                    state_d = WAIT_NEW_LOW;
                end else begin
                    gap_d = gap_cnt + GW'(1);
                end
            end
            WAIT_NEW_LOW: begin
                cpuclk_d = 1'b0;
                if (!s_src[sel] || wait_hit) begin
                    busy_d  = 1'b0;
                    wait_d  = '0;
                    state_d = RUN;
                end else begin
                    wait_d = wait_cnt + WW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - directed self-checking bench for clock_switch_ctrl
module tb_clock_switch_ctrl;

    localparam int DEB  = 8;
    localparam int GAPC = 4;
    localparam int WMAX = 32;

    logic clk = 1'b0;
    logic n_reset = 1'b1;
    logic mhz50 = 1'b0, khz31 = 1'b0, mhz2 = 1'b0, hz_gen = 1'b0, hz_hold = 1'b0;
    logic hz250;
    logic [1:0] sw = 2'b00;
    logic cpuclk, busy, sw_ack;
    logic [1:0] sel;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] h0 = '0, h1 = '0, h2 = '0;
    int   run_len, min_run;
    logic prev_cpu;
    bit   run_started;

    assign hz250 = hz_gen | hz_hold;

    always #5 clk = ~clk;
    initial begin #2; forever #20  mhz50  = ~mhz50;  end
    initial begin #2; forever #60  mhz2   = ~mhz2;   end
    initial begin #2; forever #150 khz31  = ~khz31;  end
    initial begin #2; forever #300 hz_gen = ~hz_gen; end

    clock_switch_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .GAP_CYCLES      (GAPC),
        .WAIT_MAX        (WMAX),
        .SYNC_STAGES     (2)
    ) dut (
        .pll0_250MHz (clk),
        .n_reset     (n_reset),
        .MHz50       (mhz50),
        .KHz31       (khz31),
        .MHz2        (mhz2),
        .Hz250       (hz250),
        .sw          (sw),
        .cpuclk      (cpuclk),
        .sel         (sel),
        .busy        (busy),
        .sw_ack      (sw_ack)
    );

    // One sample-clock step; h2 holds the source pins as sampled two edges ago.
    task automatic step();
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = h0;
        h0 = {mhz50, khz31, mhz2, hz250};
        if (cpuclk !== prev_cpu) begin
            if (run_started && run_len < min_run) min_run = run_len;
            run_started = 1'b1;
            run_len     = 1;
            prev_cpu    = cpuclk;
        end else begin
            run_len++;
        end
    endtask

    task automatic track_start();
        run_started = 1'b0;
        run_len     = 0;
        min_run     = 1000;
        prev_cpu    = cpuclk;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        repeat (3) step();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        int lat_err = 0, acks = 0, busys = 0, bad_sel = 0, toggles = 0;
        logic last;
        sw = 2'b00;
        #1 n_reset = 1'b0;
        #1;
        vectors++; if (cpuclk !== 1'b0) begin miscompares++; $display("FAIL reset_cpuclk: got %b want 0", cpuclk); end
        vectors++; if (sel !== 2'b00)   begin miscompares++; $display("FAIL reset_sel: got %b want 00", sel); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (sw_ack !== 1'b0) begin miscompares++; $display("FAIL reset_sw_ack: got %b want 0", sw_ack); end
        repeat (3) step();
        n_reset = 1'b1;
        last = cpuclk;
        for (int k = 1; k <= 120; k++) begin
            step();
            if (k >= 3 && cpuclk !== h2[0]) lat_err++;
            if (sw_ack) acks++;
            if (busy) busys++;
            if (sel !== 2'b00) bad_sel++;
            if (cpuclk !== last) toggles++;
            last = cpuclk;
        end
        vectors++; if (lat_err != 0) begin miscompares++; $display("FAIL reset_hz250_latency: got %0d late samples want 0", lat_err); end
        vectors++; if (toggles < 2)  begin miscompares++; $display("FAIL reset_cpuclk_toggles: got %0d want >=2", toggles); end
        vectors++; if (acks != 0)    begin miscompares++; $display("FAIL reset_no_ack: got %0d want 0", acks); end
        vectors++; if (busys != 0)   begin miscompares++; $display("FAIL reset_no_busy: got %0d want 0", busys); end
        vectors++; if (bad_sel != 0) begin miscompares++; $display("FAIL reset_sel_hold: got %0d want 0", bad_sel); end
    endtask

    task automatic test_switch_50m();
        int ack_step = -1, ack_width = 0, sel_step = -1, drop_step = -1;
        int lowrun = 0, low_at_sel = 0, new_hi_err = 0, lat_err = 0;
        logic busy_at_ack = 1'b0, cpu_at_drop = 1'b1;
        sw = 2'b11;
        track_start();
        for (int k = 1; k <= 300; k++) begin
            step();
            if (sw_ack) begin
                if (ack_step < 0) begin ack_step = k; busy_at_ack = busy; end
                ack_width++;
            end
            lowrun = cpuclk ? 0 : lowrun + 1;
            if (sel_step < 0 && sel == 2'b11) begin sel_step = k; low_at_sel = lowrun; end
            if (sel_step >= 0 && drop_step < 0 && busy && cpuclk) new_hi_err++;
            if (sel_step >= 0 && drop_step < 0 && !busy) begin drop_step = k; cpu_at_drop = cpuclk; end
            if (drop_step >= 0 && k >= drop_step + 1 && cpuclk !== h2[3]) lat_err++;
            if (drop_step >= 0 && k >= drop_step + 40) break;
        end
        vectors++; if (ack_step != 12)   begin miscompares++; $display("FAIL sw50_ack_step: got %0d want 12", ack_step); end
        vectors++; if (ack_width != 1)   begin miscompares++; $display("FAIL sw50_ack_width: got %0d want 1", ack_width); end
        vectors++; if (busy_at_ack !== 1'b1) begin miscompares++; $display("FAIL sw50_busy_at_ack: got %b want 1", busy_at_ack); end
        vectors++; if (sel_step <= 0)    begin miscompares++; $display("FAIL sw50_sel_reached: got %0d want >0", sel_step); end
        vectors++; if (low_at_sel < GAPC + 1) begin miscompares++; $display("FAIL sw50_gap_low: got %0d want >=%0d", low_at_sel, GAPC + 1); end
        vectors++; if (new_hi_err != 0)  begin miscompares++; $display("FAIL sw50_held_low: got %0d want 0", new_hi_err); end
        vectors++; if (drop_step <= 0)   begin miscompares++; $display("FAIL sw50_busy_drop: got %0d want >0", drop_step); end
        vectors++; if (cpu_at_drop !== 1'b0) begin miscompares++; $display("FAIL sw50_low_at_release: got %b want 0", cpu_at_drop); end
        vectors++; if (lat_err != 0)     begin miscompares++; $display("FAIL sw50_follow_mhz50: got %0d want 0", lat_err); end
        vectors++; if (min_run < 2)      begin miscompares++; $display("FAIL sw50_min_phase: got %0d want >=2", min_run); end
    endtask

    task automatic test_bounce();
        int acks = 0, busys = 0, bad_sel = 0;
        sw = 2'b00;
        apply_reset();
        for (int k = 0; k < 80; k++) begin
            sw = (k < 50 && ((k / 3) % 2 == 0)) ? 2'b01 : 2'b00;
            step();
            if (sw_ack) acks++;
            if (busy) busys++;
            if (sel !== 2'b00) bad_sel++;
        end
        vectors++; if (acks != 0)    begin miscompares++; $display("FAIL bounce_no_ack: got %0d want 0", acks); end
        vectors++; if (busys != 0)   begin miscompares++; $display("FAIL bounce_no_busy: got %0d want 0", busys); end
        vectors++; if (bad_sel != 0) begin miscompares++; $display("FAIL bounce_sel_hold: got %0d want 0", bad_sel); end
    endtask

    task automatic test_change_during_switch();
        int acks = 0, first_sel = -1, fall_before2 = 0;
        logic prev_busy;
        sw = 2'b10;
        track_start();
        prev_busy = busy;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (sw_ack) begin
                acks++;
                if (acks == 1) sw = 2'b01;
            end
            if (first_sel < 0 && sel != 2'b00) first_sel = int'(sel);
            if (prev_busy && !busy && acks == 1) fall_before2 = 1;
            prev_busy = busy;
            if (acks == 2 && !busy && sel == 2'b01) break;
        end
        vectors++; if (acks != 2)         begin miscompares++; $display("FAIL chg_ack_count: got %0d want 2", acks); end
        vectors++; if (first_sel != 2)    begin miscompares++; $display("FAIL chg_first_sel: got %0d want 2", first_sel); end
        vectors++; if (fall_before2 != 1) begin miscompares++; $display("FAIL chg_busy_drop_between: got %0d want 1", fall_before2); end
        vectors++; if (sel !== 2'b01)     begin miscompares++; $display("FAIL chg_final_sel: got %b want 01", sel); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL chg_final_busy: got %b want 0", busy); end
        vectors++; if (min_run < 2)       begin miscompares++; $display("FAIL chg_min_phase: got %0d want >=2", min_run); end
    endtask

    task automatic test_timeout();
        int ack_step = -1, low_step = -1, sel_step = -1, drop_step = -1;
        hz_hold = 1'b1;
        sw = 2'b00;
        apply_reset();
        sw = 2'b01;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (ack_step < 0 && sw_ack) ack_step = k;
            if (low_step < 0 && k >= 3 && !cpuclk) low_step = k;
            if (sel_step < 0 && sel == 2'b01) sel_step = k;
            if (sel_step > 0 && drop_step < 0 && !busy) begin drop_step = k; break; end
        end
        vectors++; if (ack_step != 12) begin miscompares++; $display("FAIL tmo_ack_step: got %0d want 12", ack_step); end
        vectors++; if (low_step != 45) begin miscompares++; $display("FAIL tmo_forced_low: got %0d want 45", low_step); end
        vectors++; if (sel_step != 49) begin miscompares++; $display("FAIL tmo_sel_step: got %0d want 49", sel_step); end
        vectors++; if (drop_step <= 0) begin miscompares++; $display("FAIL tmo_busy_drop: got %0d want >0", drop_step); end
        vectors++; if (sel !== 2'b01)  begin miscompares++; $display("FAIL tmo_final_sel: got %b want 01", sel); end
        hz_hold = 1'b0;
    endtask

    task automatic test_reset_mid_gap();
        int lows = 0, found = 0, ack_step = -1, drop_step = -1;
        sw = 2'b10;
        for (int k = 1; k <= 200; k++) begin
            step();
            lows = (busy && !cpuclk && sel == 2'b01) ? lows + 1 : 0;
            if (lows == 2) begin found = 1; break; end
        end
        vectors++; if (found != 1) begin miscompares++; $display("FAIL rgap_reached_gap: got %0d want 1", found); end
        #2 n_reset = 1'b0;
        #1;
        vectors++; if (sel !== 2'b00)   begin miscompares++; $display("FAIL rgap_async_sel: got %b want 00", sel); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rgap_async_busy: got %b want 0", busy); end
        vectors++; if (cpuclk !== 1'b0) begin miscompares++; $display("FAIL rgap_async_cpuclk: got %b want 0", cpuclk); end
        repeat (3) step();
        n_reset = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (ack_step < 0 && sw_ack) ack_step = k;
            if (ack_step > 0 && drop_step < 0 && !busy) begin drop_step = k; break; end
        end
        vectors++; if (ack_step != 12) begin miscompares++; $display("FAIL rgap_reswitch_ack: got %0d want 12", ack_step); end
        vectors++; if (drop_step <= 0) begin miscompares++; $display("FAIL rgap_reswitch_done: got %0d want >0", drop_step); end
        vectors++; if (sel !== 2'b10)  begin miscompares++; $display("FAIL rgap_final_sel: got %b want 10", sel); end
    endtask

    initial begin
        test_reset();
        test_switch_50m();
        test_bounce();
        test_change_during_switch();
        test_timeout();
        test_reset_mid_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
